// File: rtl/mp_addsub_pkg.sv
// Shared types and constants for the byte-serial multi-precision adder/subtractor.
package mp_addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/byte_addsub_slice.sv
// One byte of add/subtract: b is inverted for subtraction, carry-in supplies the +1.
// Purely combinational; the top time-multiplexes a single instance across bytes.
module byte_addsub_slice
  import mp_addsub_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              sub,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);
  logic [BYTE_W-1:0] w_b_eff;

  assign w_b_eff     = b ^ {BYTE_W{sub}};
  assign {cout, sum} = {1'b0, a} + {1'b0, w_b_eff} + {{BYTE_W{1'b0}}, cin};
endmodule

// File: rtl/mp_addsub_seq.sv
// Sequential W-bit add/subtract, one byte per clock through a single byte slice.
// Result appears NBYTES edges after acceptance and is held in DONE until out_ready.
module mp_addsub_seq
  import mp_addsub_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NBYTES*BYTE_W-1:0]   op_a,
  input  logic [NBYTES*BYTE_W-1:0]   op_b,
  input  logic                       sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NBYTES*BYTE_W-1:0]   result,
  output logic                       cout,
  output logic                       ovf
);
  localparam int W     = NBYTES * BYTE_W;
  localparam int IDX_W = $clog2(NBYTES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_sub;
  logic [W-1:0]      r_result;
  logic              r_cout;
  logic              r_ovf;
  logic              r_carry;
  logic [IDX_W-1:0]  r_idx;

  logic [BYTE_W-1:0] w_a_byte;
  logic [BYTE_W-1:0] w_b_byte;
  logic [BYTE_W-1:0] w_sum;
  logic              w_c;
  logic              w_last;

  assign w_last = (r_idx == IDX_W'(NBYTES - 1));

  // Byte selection by compare rather than a computed part-select keeps widths explicit.
  always_comb begin
    w_a_byte = '0;
    w_b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_byte = r_a[i*BYTE_W +: BYTE_W];
        w_b_byte = r_b[i*BYTE_W +: BYTE_W];
      end
    end
  end

  byte_addsub_slice u_slice (
    .a    (w_a_byte),
    .b    (w_b_byte),
    .sub  (r_sub),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_c)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_sub   <= sub;
            r_carry <= sub;
            r_idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IDX_W'(i)) r_result[i*BYTE_W +: BYTE_W] <= w_sum;
          end
          r_carry <= w_c;
          if (w_last) begin
            r_cout <= w_c;
            // Signed overflow: operands (b already conditioned) agree in sign, sum does not.
            r_ovf  <= (r_a[W-1] == (r_b[W-1] ^ r_sub)) && (w_sum[BYTE_W-1] != r_a[W-1]);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
endmodule

// File: tb/tb_mp_addsub_seq.sv
// Directed bench for mp_addsub_seq at NBYTES=4 with hand-computed expected values.
module tb_mp_addsub_seq;
  localparam int NBYTES = 4;
  localparam int W      = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int n_checks   = 0;
  int n_failures = 0;

  mp_addsub_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one request, scrambles the inputs afterwards, waits for DONE and checks it.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] exp_r,
                        input logic exp_c, input logic exp_o, input logic release_out);
    int n;
    check({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
    op_a     = a;
    op_b     = b;
    sub      = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a     = ~a;
    op_b     = a ^ 32'h5A5A_A5A5;
    sub      = ~s;
    n = 0;
    while (n < 20) begin
      if (out_valid) break;
      tick();
      n++;
    end
    check({tag, ".latency"}, n, NBYTES);
    check({tag, ".result"}, result, exp_r);
    check({tag, ".cout"}, {31'b0, cout}, {31'b0, exp_c});
    check({tag, ".ovf"}, {31'b0, ovf}, {31'b0, exp_o});
    if (release_out) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, ".idle_ready"}, {31'b0, in_ready}, 32'd1);
      check({tag, ".idle_valid"}, {31'b0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst.in_ready", {31'b0, in_ready}, 32'd1);
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.result", result, 32'h0);
    check("rst.cout", {31'b0, cout}, 32'd0);
    check("rst.ovf", {31'b0, ovf}, 32'd0);

    run_op("add_carry",  32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b1);
    run_op("sub_borrow", 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("sub_pos",    32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    run_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);

    // Backpressure: hold DONE for 5 cycles with a stray request in the window.
    run_op("bp", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      op_a     = 32'hDEAD_BEEF;
      op_b     = 32'h0000_0001;
      tick();
      in_valid = 1'b0;
      check("bp.result", result, 32'h2345_6789);
      check("bp.cout", {31'b0, cout}, 32'd0);
      check("bp.ovf", {31'b0, ovf}, 32'd0);
      check("bp.in_ready", {31'b0, in_ready}, 32'd0);
      check("bp.out_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("bp.no_stray_valid", {31'b0, out_valid}, 32'd0);
    run_op("bp_next", 32'h0000_0010, 32'h0000_0020, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1);

    // Reset after byte 1 has been processed aborts the operation.
    op_a     = 32'h0101_0101;
    op_b     = 32'h0202_0202;
    sub      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.in_ready", {31'b0, in_ready}, 32'd1);
    check("abort.out_valid", {31'b0, out_valid}, 32'd0);
    check("abort.result", result, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort.never_valid", {31'b0, seen}, 32'd0);

    run_op("post_abort", 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end
endmodule

// File: doc/mp_addsub_seq.md
MP_ADDSUB_SEQ -- requirements
Module: mp_addsub_seq

Interface
REQ-001 Parameter: NBYTES, default 4, number of 8-bit bytes per operand; operand width W = 8*NBYTES; legal range 2..16.
REQ-002 Port: clk  input  1  the single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  operand request present.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: op_a  input  W  minuend/augend.
REQ-007 Port: op_b  input  W  subtrahend/addend.
REQ-008 Port: sub  input  1  0 = a+b, 1 = a-b.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes result.
REQ-011 Port: result  output  W  sum/difference modulo 2^W.
REQ-012 Port: cout  output  1  final carry out of byte NBYTES-1 (for sub, 1 = no borrow, i.e. a >= b unsigned).
REQ-013 Port: ovf  output  1  two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both are decoded from state.
REQ-016 In IDLE with in_valid=1, the block SHALL capture op_a, op_b and sub, set byte index to 0, set carry to sub and enter RUN; in IDLE with in_valid=0 it SHALL hold.
REQ-017 In RUN, each edge SHALL process byte i: {c, s} = a[i] + (b[i] XOR {8{sub}}) + carry; s is written to result byte i, carry <= c, and i increments.
REQ-018 When byte NBYTES-1 is processed, the block SHALL latch cout = c, set ovf = (a_msb == b'_msb) AND (s_msb != a_msb), where b' = b XOR {W{sub}}, and enter DONE.
REQ-019 Latency SHALL be exactly NBYTES edges from the accepting edge to out_valid=1. No early or partial output.
REQ-020 In DONE, result, cout and ovf SHALL remain stable until out_ready=1; the edge with out_ready=1 SHALL return the block to IDLE.
REQ-021 No request is accepted in RUN or DONE. in_valid, op_a, op_b and sub are ignored outside IDLE. Minimum initiation interval is NBYTES+2 cycles.
REQ-022 Operand changes after acceptance SHALL NOT affect the result, because captured copies are used.
REQ-023 Result bytes not yet processed in RUN SHALL hold their previous values. Only the DONE-state values are architecturally visible.
REQ-024 Byte index SHALL be ceil(log2(NBYTES)) bits wide and SHALL never wrap past NBYTES-1.

Reset
REQ-025 When rst=1 at an edge, the block SHALL enter IDLE with result=0, cout=0, ovf=0, carry=0 and index=0. Therefore in_ready=1 and out_valid=0 in the following cycle.
REQ-026 Reset SHALL take priority over every other event, including acceptance and out_ready handshakes. An operation in RUN or DONE SHALL be discarded without producing output.

Structure
REQ-027 The package mp_addsub_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the constant BYTE_W=8.
REQ-028 The combinational byte step SHALL be one sub-module, byte_addsub_slice, with ports a[8], b[8], sub, cin, sum[8] and cout.
REQ-029 Exactly one byte_addsub_slice instance SHALL be used, time-multiplexed across bytes; there is no combinational path from inputs to outputs.

Verification (NBYTES=4)
REQ-030 Add: a=0x000000FF, b=0x00000001, sub=0 -> result=0x00000100, cout=0, ovf=0, out_valid exactly 4 edges after acceptance.
REQ-031 Sub: a=0x00000000, b=0x00000001, sub=1 -> result=0xFFFFFFFF, cout=0 (borrow), ovf=0; then a=0x00000005, b=0x00000003 -> result=0x00000002, cout=1.
REQ-032 Overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> result=0x80000000, ovf=1, cout=0; a=0xFFFFFFFF, b=0x00000001 -> result=0x00000000, cout=1, ovf=0.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result, cout and ovf stay stable and in_ready=0. A new in_valid pulse in that window is not accepted. After out_ready=1, the block is IDLE and the next request is accepted.
REQ-034 Reset mid-op: assert rst for 1 cycle after byte 1 is processed -> next cycle in_ready=1, out_valid=0, result=0, and no out_valid ever appears for the aborted request.
